led_breath_ctrl: RTL and testbench

User-visible LED controller clocked by the 60 MHz PLLVR output (27 MHz × 20 / 9) on the Tang Nano 4K. It synchronizes and debounces the on-board push button. Each press cycles the LED through four modes: OFF, ON, BLINK and BREATHE. BREATHE is a triangle-ramped PWM dimmer. The block stays in its reset state until the PLL reports lock.

---
 rtl/led_pkg.sv | 8 +
 rtl/key_debounce.sv | 41 ++++
 rtl/led_breath_ctrl.sv | 87 ++++++++
 tb/tb_led_breath_ctrl.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/led_pkg.sv
// led_pkg: shared mode/direction types and clock helpers for the LED controller
package led_pkg;
  typedef enum logic [1:0] {MODE_OFF, MODE_ON, MODE_BLINK, MODE_BREATHE} led_mode_t;
  typedef enum logic {DIR_UP, DIR_DOWN} breathe_dir_t;
  function automatic int cyc_per_ms(input int clk_hz);
    return clk_hz / 1000;
  endfunction
endpackage

// File: rtl/key_debounce.sv
// key_debounce: two-flop synchronizer, debounce counter and single-cycle press pulse
module key_debounce #(
  parameter int DEBOUNCE_CYC = 20
) (
  input  logic clk,
  input  logic rst,
  input  logic key_n,
  output logic press
);
  localparam int CW = $clog2(DEBOUNCE_CYC + 1);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYC - 1);
  logic s1, s2, db, armed, hit;
  logic [CW-1:0] cnt;
  assign hit = cnt == LAST;
  // after reset the key must be seen released for a full window before any press counts
  always_ff @(posedge clk) begin
    if (rst) begin
      s1 <= 1'b1;
      s2 <= 1'b1;
      db <= 1'b1;
      armed <= 1'b0;
      cnt <= '0;
      press <= 1'b0;
    end else begin
      s1 <= key_n;
      s2 <= s1;
      press <= armed && hit && db && !s2;
      if (!armed) begin
        cnt <= (s2 && !hit) ? cnt + 1'b1 : '0;
        armed <= s2 && hit;
      end else if (s2 == db) begin
        cnt <= '0;
      end else if (hit) begin
        db <= s2;
        cnt <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end
endmodule

// File: rtl/led_breath_ctrl.sv
// led_breath_ctrl: button-cycled LED controller with OFF/ON/BLINK/BREATHE modes
module led_breath_ctrl import led_pkg::*; #(
  parameter int CLK_FREQ_HZ = 60000000,
  parameter int PWM_BITS = 8,
  parameter int STEP_MS = 4,
  parameter int BLINK_MS = 500,
  parameter int DEBOUNCE_MS = 20,
  parameter bit LED_ACTIVE_LOW = 1'b1
) (
  input  logic clkin,
  input  logic reset,
  input  logic pll_lock,
  input  logic key_n,
  output logic led,
  output logic [1:0] mode
);
  localparam int CPM = cyc_per_ms(CLK_FREQ_HZ);
  localparam int PW = $clog2(CPM);
  localparam int SW = $clog2(STEP_MS + 1);
  localparam int BW = $clog2(BLINK_MS + 1);
  localparam logic [PW-1:0] PRE_LAST = PW'(CPM - 1);
  localparam logic [SW-1:0] STEP_LAST = SW'(STEP_MS - 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_MS - 1);
  localparam logic [PWM_BITS-1:0] DUTY_MAX = '1;
  localparam logic [PWM_BITS-1:0] PWM_LAST = DUTY_MAX - 1'b1;
  logic rst_i, press, ms_tick, step, pwm_on, blink_lvl, led_lvl, turn;
  logic [PW-1:0] pre;
  logic [SW-1:0] step_cnt;
  logic [BW-1:0] blink_cnt;
  logic [PWM_BITS-1:0] pwm_cnt, duty, duty_nx;
  led_mode_t mode_q;
  breathe_dir_t dir, dir_nx;
  assign rst_i = reset | ~pll_lock;
  assign mode = mode_q;
  assign ms_tick = pre == PRE_LAST;
  assign step = ms_tick && step_cnt == STEP_LAST;
  assign pwm_on = pwm_cnt < duty;
  assign led_lvl = mode_q == MODE_OFF ? 1'b0 : mode_q == MODE_ON ? 1'b1 :
                   mode_q == MODE_BLINK ? blink_lvl : pwm_on;
  key_debounce #(.DEBOUNCE_CYC(DEBOUNCE_MS * CPM)) u_key (
    .clk(clkin),
    .rst(rst_i),
    .key_n(key_n),
    .press(press)
  );
  // turning points reverse direction and step back so duty never wraps
  always_comb begin
    turn = dir == DIR_UP ? duty == DUTY_MAX : duty == '0;
    dir_nx = dir;
    duty_nx = duty;
    if (press) begin
      dir_nx = DIR_UP;
      duty_nx = '0;
    end else if (step && mode_q == MODE_BREATHE) begin
      dir_nx = turn ? (dir == DIR_UP ? DIR_DOWN : DIR_UP) : dir;
      duty_nx = ((dir == DIR_UP) ^ turn) ? duty + 1'b1 : duty - 1'b1;
    end
  end
  always_ff @(posedge clkin) begin
    if (rst_i) begin
      pre <= '0;
      step_cnt <= '0;
      pwm_cnt <= '0;
      blink_cnt <= '0;
      blink_lvl <= 1'b0;
      mode_q <= MODE_BREATHE;
      duty <= '0;
      dir <= DIR_UP;
      led <= LED_ACTIVE_LOW;
    end else begin
      pre <= ms_tick ? '0 : pre + 1'b1;
      if (ms_tick) step_cnt <= step_cnt == STEP_LAST ? '0 : step_cnt + 1'b1;
      pwm_cnt <= pwm_cnt == PWM_LAST ? '0 : pwm_cnt + 1'b1;
      duty <= duty_nx;
      dir <= dir_nx;
      if (press) begin
        mode_q <= led_mode_t'(mode_q + 1'b1);
        blink_cnt <= '0;
        blink_lvl <= 1'b0;
      end else if (ms_tick && mode_q == MODE_BLINK) begin
        blink_cnt <= blink_cnt == BLINK_LAST ? '0 : blink_cnt + 1'b1;
        blink_lvl <= blink_lvl ^ (blink_cnt == BLINK_LAST);
      end
      led <= led_lvl ^ LED_ACTIVE_LOW;
    end
  end
endmodule

// File: tb/tb_led_breath_ctrl.sv
// tb_led_breath_ctrl: time-based reference model plus directed checks of led_breath_ctrl
module tb_led_breath_ctrl;
  logic clkin = 1'b0, reset = 1'b1, pll_lock = 1'b0, key_n = 1'b1;
  logic led;
  logic [1:0] mode;
  int total = 0, bad = 0, cyc = 0, c = 0, e = 0, m_mode = 3;
  logic rst_s = 1'b1;
  bit pend = 1'b1;
  int evq[$];

  led_breath_ctrl #(
    .CLK_FREQ_HZ(10000), .PWM_BITS(4), .STEP_MS(1), .BLINK_MS(3), .DEBOUNCE_MS(2), .LED_ACTIVE_LOW(1'b1)
  ) dut (
    .clkin(clkin), .reset(reset), .pll_lock(pll_lock), .key_n(key_n), .led(led), .mode(mode)
  );

  always #5 clkin = ~clkin;
  always @(posedge clkin) begin
    cyc <= cyc + 1;
    rst_s <= reset | ~pll_lock;
  end

  task automatic chk(input string nm, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s at cyc %0d: got %0d expected %0d", nm, cyc, got, exp);
    end
  endtask

  // triangle duty after k steps from 0, period 30 steps for 4-bit duty
  function automatic int tri_duty(input int k);
    int m = k % 30;
    return m <= 15 ? m : 30 - m;
  endfunction

  // logical LED level given mode, cycles since lock c and mode entry cycle e (10 cyc/ms, 15-cyc PWM)
  function automatic bit lvl_of(input int md, input int cc, input int ee);
    int k = cc / 10 - ee / 10;
    case (md)
      0: return 1'b0;
      1: return 1'b1;
      2: return bit'((k / 3) % 2);
      default: return (cc % 15) < tri_duty(k);
    endcase
  endfunction

  initial begin : model
    bit exp_led;
    forever begin
      @(negedge clkin);
      if (rst_s) begin
        c = 0;
        e = 0;
        m_mode = 3;
        evq.delete();
        exp_led = 1'b1;
      end else begin
        c++;
        exp_led = pend;
        if (evq.size() > 0 && evq[0] == cyc) begin
          void'(evq.pop_front());
          m_mode = (m_mode + 1) % 4;
          e = c;
        end
      end
      pend = !lvl_of(m_mode, c, e);
      chk("model_mode", mode, m_mode);
      chk("model_led", led, exp_led);
    end
  end

  task automatic press(input int exp);
    int n = 0;
    key_n = 1'b0;
    evq.push_back(cyc + 23);
    do begin
      @(posedge clkin); #1;
      n++;
    end while (mode != exp[1:0] && n < 40);
    chk("press_latency", n, 23);
    chk("press_mode", mode, exp);
  endtask

  task automatic release_key();
    key_n = 1'b1;
    repeat (30) @(posedge clkin);
    #1;
  endtask

  task automatic wait_c(input int t);
    int n = 0;
    do begin
      @(negedge clkin); #1;
      n++;
    end while (c != t && n < 1000);
    chk("wait_c", c, t);
  endtask

  initial begin : stim
    int n, m;
    repeat (3) @(posedge clkin);
    #1 reset = 1'b0;
    repeat (50) begin
      @(posedge clkin); #1;
      chk("lock_low_mode", mode, 3);
      chk("lock_low_led", led, 1);
    end
    pll_lock = 1'b1;
    n = 0;
    do begin
      @(posedge clkin); #1;
      n++;
    end while (led != 1'b0 && n < 100);
    chk("first_pwm_on", n, 16);
    wait_c(150);
    chk("duty_peak", dut.duty, 15);
    wait_c(160);
    chk("duty_after_peak", dut.duty, 14);
    wait_c(300);
    chk("duty_floor", dut.duty, 0);
    wait_c(310);
    chk("duty_after_floor", dut.duty, 1);
    key_n = 1'b0;
    repeat (15) @(posedge clkin);
    #1 key_n = 1'b1;
    repeat (30) @(posedge clkin);
    #1 chk("glitch_mode", mode, 3);
    press(0);
    repeat (17) @(posedge clkin);
    #1 release_key();
    chk("off_led", led, 1);
    press(1);
    @(posedge clkin); #1;
    m = 0;
    repeat (30) begin
      @(posedge clkin); #1;
      if (led !== 1'b0) m++;
    end
    chk("on_led_high_cycles", m, 0);
    release_key();
    press(2);
    @(posedge clkin); #1;
    chk("blink_entry_led", led, 1);
    n = 0;
    do begin
      @(posedge clkin); #1;
      n++;
    end while (led != 1'b0 && n < 100);
    m = 0;
    do begin
      @(posedge clkin); #1;
      m++;
    end while (led != 1'b1 && m < 100);
    chk("blink_half_period", m, 30);
    release_key();
    press(3);
    release_key();
    press(0);
    release_key();
    press(1);
    release_key();
    press(2);
    repeat (5) @(posedge clkin);
    #1 pll_lock = 1'b0;
    @(posedge clkin); #1;
    chk("lock_drop_mode", mode, 3);
    repeat (4) @(posedge clkin);
    #1 pll_lock = 1'b1;
    repeat (60) @(posedge clkin);
    #1 chk("held_no_event", mode, 3);
    release_key();
    n = 0;
    do begin
      @(negedge clkin); #1;
      n++;
    end while (c % 10 != 7 && n < 20);
    press(0);
    chk("coin_duty", dut.duty, 0);
    chk("coin_dir", dut.dir, 0);
    release_key();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
